// File: rtl/fifo_stream_adapter_if.sv
// Purpose : bundles the FIFO pop-side and output-stream signals of fifo_stream_adapter.
// Latency : none, wiring only.
// Backpressure: carries m_ready_in from the downstream sink back to the adapter.
// Ports   : fifo_empty_in/fifo_data_in/fifo_valid_in/fifo_deq_out (FIFO side),
//           m_valid_out/m_data_out/m_last_out/m_ready_in (stream side).
//           master = adapter view, slave = FIFO + sink view.
interface fifo_stream_adapter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  fifo_empty_in;
  logic [DATA_WIDTH-1:0] fifo_data_in;
  logic                  fifo_valid_in;
  logic                  fifo_deq_out;
  logic                  m_valid_out;
  logic [DATA_WIDTH-1:0] m_data_out;
  logic                  m_last_out;
  logic                  m_ready_in;

  modport master (
    input  fifo_empty_in, fifo_data_in, fifo_valid_in, m_ready_in,
    output fifo_deq_out, m_valid_out, m_data_out, m_last_out
  );

  modport slave (
    output fifo_empty_in, fifo_data_in, fifo_valid_in, m_ready_in,
    input  fifo_deq_out, m_valid_out, m_data_out, m_last_out
  );
endinterface

// File: rtl/fifo_stream_adapter.sv
// Purpose : drains a 1-cycle-latency FIFO pop port into a registered valid/ready
//           stream framed into BURST_LEN-word bursts, via a 2-entry skid buffer.
// Latency : 2 cycles from fifo_deq_out to m_valid_out; 1 word/cycle sustained.
// Backpressure: at most 2 words held; deq stops once occupancy + in-flight reaches 2.
// Ports   : clk_in, rst_in (sync, active-high); bus (fifo_stream_adapter_if.master);
//           protocol_err_out (sticky); checksum_out / checksum_valid_out only when
//           FIFO_STREAM_CHECKSUM_EN is defined (per-burst modular sum + 1-cycle strobe).
module fifo_stream_adapter #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  fifo_stream_adapter_if.master bus,
  output logic                  protocol_err_out
`ifdef FIFO_STREAM_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum_out,
  output logic                  checksum_valid_out
`endif
);

  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic                  err_q, err_d;

  logic       pop;
  logic       capture;
  logic       deq;
  logic       last_beat;
  logic [2:0] fill;

  assign pop       = bus.m_valid_out & bus.m_ready_in;
  assign capture   = bus.fifo_valid_in & inflight_q;
  assign last_beat = (beat_q == LAST_BEAT);

  // Words already held plus the one returning, minus the one leaving now.
  // pop implies occ_q >= 1, so this never wraps.
  assign fill = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
  assign deq  = !rst_in && !bus.fifo_empty_in && (fill < 3'd2);

  assign bus.fifo_deq_out = deq;
  assign bus.m_valid_out  = (occ_q != 2'd0);
  assign bus.m_data_out   = head_q;
  assign bus.m_last_out   = bus.m_valid_out && last_beat;
  assign protocol_err_out = err_q;

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    beat_d = beat_q;
    err_d  = err_q | (bus.fifo_valid_in & ~inflight_q);

    // head_q is always the oldest word; tail_q only matters when occ_q == 2.
    case ({capture, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = bus.fifo_data_in;
        else               tail_d = bus.fifo_data_in;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          head_d = bus.fifo_data_in;
        end else begin
          head_d = tail_q;
          tail_d = bus.fifo_data_in;
        end
      end
      default: ;
    endcase

    if (pop) beat_d = last_beat ? '0 : beat_q + BEAT_W'(1);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      beat_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= deq;
      head_q     <= head_d;
      tail_q     <= tail_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
    end
  end

`ifdef FIFO_STREAM_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] cks_q, cks_d;
  logic                  cks_vld_q, cks_vld_d;

  always_comb begin
    acc_d     = acc_q;
    cks_d     = cks_q;
    cks_vld_d = 1'b0;
    if (pop) begin
      if (last_beat) begin
        // Publish the completed burst including the word leaving now.
        cks_d     = acc_q + head_q;
        cks_vld_d = 1'b1;
        acc_d     = '0;
      end else begin
        acc_d = acc_q + head_q;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      acc_q     <= '0;
      cks_q     <= '0;
      cks_vld_q <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cks_q     <= cks_d;
      cks_vld_q <= cks_vld_d;
    end
  end

  assign checksum_out       = cks_q;
  assign checksum_valid_out = cks_vld_q;
`endif

endmodule
